fp_mult_pipe: RTL and testbench

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

---
 rtl/fp_mult_pkg.sv | 38 +++
 rtl/fp_mult_round.sv | 151 +++++++++++++++
 rtl/fp_mult_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared constants for the pipelined floating-point multiplier.
// Holds the flag bit positions, rounding-mode encodings, the special-value
// classification carried down the pipe and the canonical-NaN builder.
package fp_mult_pkg;

   // Bit positions inside flags = {invalid, divzero, overflow, underflow, inexact}
   localparam int FLAG_INVALID   = 4;
   localparam int FLAG_DIVZERO   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   // Rounding-mode encodings
   localparam logic [1:0] RND_RNE = 2'd0;
   localparam logic [1:0] RND_RTZ = 2'd1;
   localparam logic [1:0] RND_RUP = 2'd2;
   localparam logic [1:0] RND_RDN = 2'd3;

   // What the operand pair resolves to before any arithmetic is looked at
   typedef enum logic [1:0] {
      KIND_NORM = 2'd0,
      KIND_ZERO = 2'd1,
      KIND_INF  = 2'd2,
      KIND_NAN  = 2'd3
   } kind_e;

   // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
   // Returned in a 64-bit container; callers truncate to their format width.
   function automatic logic [63:0] canon_nan(input int unsigned exp_w,
                                             input int unsigned man_w);
      logic [63:0] v_exp;
      logic [63:0] v_qbit;
      v_exp  = ((64'd1 << exp_w) - 64'd1) << man_w;
      v_qbit = 64'd1 << (man_w - 32'd1);
      return v_exp | v_qbit;
   endfunction

endpackage

// File: rtl/fp_mult_round.sv
// fp_mult_round: final pipeline stage of fp_mult_pipe. Rounds the normalised
// significand, resolves overflow/underflow and special values, packs the
// result and registers result, flags, tag and the stage valid bit.
// Optional macro FP_MULT_PIPE_RND_MODE_EN only changes what reaches i_rnd;
// this stage always honours all four modes.
module fp_mult_round
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_adv,
   input  logic                   i_valid,
   input  logic                   i_sign,
   input  kind_e                  i_kind,
   input  logic                   i_invalid,
   input  logic [EXP_W+1:0]       i_exp,
   input  logic [2*MAN_W:0]       i_sig,
   input  logic [TAG_W-1:0]       i_tag,
   input  logic [1:0]             i_rnd,
   output logic                   o_valid,
   output logic [EXP_W+MAN_W:0]   o_result,
   output logic [4:0]             o_flags,
   output logic [TAG_W-1:0]       o_tag
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int EW = EXP_W + 2;
   localparam logic [EW-1:0]  EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]   NAN_VAL = W'(canon_nan(EXP_W, MAN_W));

   // i_sig has the leading one already stripped: kept mantissa, guard, round, sticky
   logic [MAN_W-1:0] w_man;
   logic             w_g;
   logic             w_r;
   logic             w_s;
   logic             w_lost;
   logic             w_inc;
   logic             w_to_inf;
   logic [MAN_W:0]   w_man_inc;
   logic [EW-1:0]    w_exp_r;
   logic             w_uf;
   logic             w_of;
   logic [W-1:0]     w_result;
   logic [4:0]       w_flags;

   logic             r_valid;
   logic [W-1:0]     r_result;
   logic [4:0]       r_flags;
   logic [TAG_W-1:0] r_tag;

   assign w_man  = i_sig[2*MAN_W:MAN_W+1];
   assign w_g    = i_sig[MAN_W];
   assign w_r    = i_sig[MAN_W-1];
   assign w_s    = |i_sig[MAN_W-2:0];
   assign w_lost = w_g | w_r | w_s;

   // Round-up decision and overflow direction for the selected mode
   always_comb begin
      w_inc    = 1'b0;
      w_to_inf = 1'b1;
      case (i_rnd)
         RND_RNE: begin
            w_inc    = w_g & (w_r | w_s | w_man[0]);
            w_to_inf = 1'b1;
         end
         RND_RTZ: begin
            w_inc    = 1'b0;
            w_to_inf = 1'b0;
         end
         RND_RUP: begin
            w_inc    = !i_sign & w_lost;
            w_to_inf = !i_sign;
         end
         RND_RDN: begin
            w_inc    = i_sign & w_lost;
            w_to_inf = i_sign;
         end
         default: begin
            w_inc    = 1'b0;
            w_to_inf = 1'b1;
         end
      endcase
   end

   // A carry out of the mantissa leaves an all-zero stored mantissa and bumps the exponent
   assign w_man_inc = {1'b0, w_man} + {{MAN_W{1'b0}}, w_inc};
   assign w_exp_r   = i_exp + EW'(w_man_inc[MAN_W]);
   assign w_uf      = w_exp_r[EW-1] || (w_exp_r == '0);
   assign w_of      = !w_exp_r[EW-1] && (w_exp_r >= EXP_MAX);

   // Pack the result and flags for every operand class
   always_comb begin
      w_result = '0;
      w_flags  = '0;
      case (i_kind)
         KIND_NAN: begin
            w_result               = NAN_VAL;
            w_flags[FLAG_INVALID]  = i_invalid;
         end
         KIND_INF: begin
            w_result = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end
         KIND_ZERO: begin
            w_result = {i_sign, {(W-1){1'b0}}};
         end
         default: begin
            if (w_uf) begin
               w_result                = {i_sign, {(W-1){1'b0}}};
               w_flags[FLAG_UNDERFLOW] = 1'b1;
               w_flags[FLAG_INEXACT]   = 1'b1;
            end else if (w_of) begin
               w_result = w_to_inf ? {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                   : {i_sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
               w_flags[FLAG_OVERFLOW] = 1'b1;
               w_flags[FLAG_INEXACT]  = 1'b1;
            end else begin
               w_result              = {i_sign, w_exp_r[EXP_W-1:0], w_man_inc[MAN_W-1:0]};
               w_flags[FLAG_INEXACT] = w_lost;
            end
         end
      endcase
      w_flags[FLAG_DIVZERO] = 1'b0;
   end

   // Output register: advances with the pipe, data only loads for a real operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_result <= '0;
         r_flags  <= '0;
         r_tag    <= '0;
      end else if (i_adv) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_result <= w_result;
            r_flags  <= w_flags;
            r_tag    <= i_tag;
         end
      end
   end

   assign o_valid  = r_valid;
   assign o_result = r_result;
   assign o_flags  = r_flags;
   assign o_tag    = r_tag;

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 4-stage pipelined floating-point multiplier
// (unpack/exceptions -> mantissa multiply -> normalise -> round/pack).
// Optional macro FP_MULT_PIPE_RND_MODE_EN adds the rnd_mode input; without it
// every operation rounds to nearest, ties to even.
//
// Handshake: an operand pair is accepted on a rising edge where
// in_valid && in_ready; a result is consumed on a rising edge where
// out_valid && out_ready. in_ready equals adv = !out_valid || out_ready, and
// every stage (bubbles included) moves only when adv is high, so a stalled
// output freezes the whole pipe.
module fp_mult_pipe
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic [TAG_W-1:0]       in_tag,
`ifdef FP_MULT_PIPE_RND_MODE_EN
   input  logic [1:0]             rnd_mode,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [4:0]             flags,
   output logic [TAG_W-1:0]       out_tag
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int EW = EXP_W + 2;
   localparam int PW = 2 * MAN_W + 2;
   localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W-1)) - 1);

   // Control travelling with each operation; exp is a two's-complement biased exponent
   typedef struct packed {
      logic             valid;
      logic             sign;
      kind_e            kind;
      logic             invalid;
      logic [EW-1:0]    exp;
      logic [TAG_W-1:0] tag;
      logic [1:0]       rnd;
   } ctl_t;

   logic             w_adv;
   logic [1:0]       w_rnd;
   logic [EXP_W-1:0] w_a_exp;
   logic [EXP_W-1:0] w_b_exp;
   logic [MAN_W-1:0] w_a_man;
   logic [MAN_W-1:0] w_b_man;
   logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan;
   logic             w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   ctl_t             w_s1_ctl;
   logic [PW-1:0]    w_s2_prod;
   logic             w_carry;
   ctl_t             w_s3_ctl;
   logic [PW-2:0]    w_s3_sig;

   ctl_t             r_s1_ctl;
   logic [MAN_W:0]   r_s1_ma;
   logic [MAN_W:0]   r_s1_mb;
   ctl_t             r_s2_ctl;
   logic [PW-1:0]    r_s2_prod;
   ctl_t             r_s3_ctl;
   logic [PW-2:0]    r_s3_sig;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

`ifdef FP_MULT_PIPE_RND_MODE_EN
   assign w_rnd = rnd_mode;
`else
   assign w_rnd = RND_RNE;
`endif

   assign w_a_exp  = a[W-2:MAN_W];
   assign w_b_exp  = b[W-2:MAN_W];
   assign w_a_man  = a[MAN_W-1:0];
   assign w_b_man  = b[MAN_W-1:0];
   assign w_a_nan  = (&w_a_exp) && (|w_a_man);
   assign w_b_nan  = (&w_b_exp) && (|w_b_man);
   assign w_a_snan = w_a_nan && !w_a_man[MAN_W-1];
   assign w_b_snan = w_b_nan && !w_b_man[MAN_W-1];
   assign w_a_inf  = (&w_a_exp) && !(|w_a_man);
   assign w_b_inf  = (&w_b_exp) && !(|w_b_man);
   // Exponent zero covers subnormals too: they are flushed to zero on input
   assign w_a_zero = (w_a_exp == '0);
   assign w_b_zero = (w_b_exp == '0);

   // Stage 1 decode: classify the pair and form the unbiased-sum exponent
   always_comb begin
      w_s1_ctl         = '0;
      w_s1_ctl.valid   = in_valid;
      w_s1_ctl.sign    = a[W-1] ^ b[W-1];
      w_s1_ctl.kind    = KIND_NORM;
      w_s1_ctl.invalid = 1'b0;
      w_s1_ctl.exp     = {2'b00, w_a_exp} + {2'b00, w_b_exp} - BIAS;
      w_s1_ctl.tag     = in_tag;
      w_s1_ctl.rnd     = w_rnd;
      if (w_a_nan || w_b_nan) begin
         w_s1_ctl.kind    = KIND_NAN;
         w_s1_ctl.invalid = w_a_snan || w_b_snan;
      end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
         w_s1_ctl.kind    = KIND_NAN;
         w_s1_ctl.invalid = 1'b1;
      end else if (w_a_inf || w_b_inf) begin
         w_s1_ctl.kind = KIND_INF;
      end else if (w_a_zero || w_b_zero) begin
         w_s1_ctl.kind = KIND_ZERO;
      end
   end

   // Stage 1 register: unpacked operands with hidden bits restored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_ctl <= '0;
         r_s1_ma  <= '0;
         r_s1_mb  <= '0;
      end else if (w_adv) begin
         r_s1_ctl <= w_s1_ctl;
         r_s1_ma  <= {1'b1, w_a_man};
         r_s1_mb  <= {1'b1, w_b_man};
      end
   end

   assign w_s2_prod = PW'(r_s1_ma) * PW'(r_s1_mb);

   // Stage 2 register: full-width significand product
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_ctl  <= '0;
         r_s2_prod <= '0;
      end else if (w_adv) begin
         r_s2_ctl  <= r_s1_ctl;
         r_s2_prod <= w_s2_prod;
      end
   end

   // Product of two values in [1,2) lies in [1,4): at most one position to fix
   assign w_carry  = r_s2_prod[PW-1];

   // Stage 3 normalise: align the leading one to the top and adjust the exponent
   always_comb begin
      w_s3_ctl     = r_s2_ctl;
      w_s3_ctl.exp = r_s2_ctl.exp + EW'(w_carry);
      w_s3_sig     = w_carry ? r_s2_prod[PW-2:0] : {r_s2_prod[PW-3:0], 1'b0};
   end

   // Stage 3 register: normalised significand without its leading one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s3_ctl <= '0;
         r_s3_sig <= '0;
      end else if (w_adv) begin
         r_s3_ctl <= w_s3_ctl;
         r_s3_sig <= w_s3_sig;
      end
   end

   fp_mult_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W),
      .TAG_W (TAG_W)
   ) u_round (
      .clk       (clk),
      .rst       (rst),
      .i_adv     (w_adv),
      .i_valid   (r_s3_ctl.valid),
      .i_sign    (r_s3_ctl.sign),
      .i_kind    (r_s3_ctl.kind),
      .i_invalid (r_s3_ctl.invalid),
      .i_exp     (r_s3_ctl.exp),
      .i_sig     (r_s3_sig),
      .i_tag     (r_s3_ctl.tag),
      .i_rnd     (r_s3_ctl.rnd),
      .o_valid   (out_valid),
      .o_result  (result),
      .o_flags   (flags),
      .o_tag     (out_tag)
   );

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed-vector bench for fp_mult_pipe (half precision).
// Define FP_MULT_PIPE_RND_MODE_EN to also exercise the directed rounding modes.
module tb_fp_mult_pipe;

   localparam int N_VEC = 17;
   localparam int SB_W  = 25;   // {tag[3:0], flags[4:0], result[15:0]}

   // Hand-computed vectors: a, b, expected result, expected flags
   localparam logic [15:0] VA [N_VEC] = '{
      16'h3E00, 16'h7C00, 16'h7BFF, 16'h0400, 16'h8400, 16'h3C00, 16'h7C00, 16'h7D00,
      16'h7E00, 16'h0001, 16'h3C01, 16'h3C01, 16'h3C03, 16'h3C01, 16'h0400, 16'h0400,
      16'h7BFF};
   localparam logic [15:0] VB [N_VEC] = '{
      16'h3E00, 16'h0000, 16'h4000, 16'h0400, 16'h0400, 16'hBC00, 16'hC000, 16'h3C00,
      16'h3C00, 16'hBC00, 16'h3C01, 16'h3E00, 16'h3E00, 16'h3FFE, 16'h3C00, 16'h3800,
      16'h3C00};
   localparam logic [15:0] VR [N_VEC] = '{
      16'h4080, 16'h7E00, 16'h7C00, 16'h0000, 16'h8000, 16'hBC00, 16'hFC00, 16'h7E00,
      16'h7E00, 16'h8000, 16'h3C02, 16'h3E02, 16'h3E04, 16'h4000, 16'h0400, 16'h0000,
      16'h7BFF};
   localparam logic [4:0] VF [N_VEC] = '{
      5'h00, 5'h10, 5'h05, 5'h03, 5'h03, 5'h00, 5'h00, 5'h10,
      5'h00, 5'h00, 5'h01, 5'h01, 5'h01, 5'h01, 5'h00, 5'h03,
      5'h00};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] result;
   logic [4:0]  flags;
   logic [3:0]  out_tag;
`ifdef FP_MULT_PIPE_RND_MODE_EN
   logic [1:0]  rnd_mode = 2'd0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [SB_W-1:0] exp_q[$];

   // Clock and reset
   always #5 clk = ~clk;

   fp_mult_pipe #(
      .EXP_W (5),
      .MAN_W (10),
      .TAG_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_tag    (in_tag),
`ifdef FP_MULT_PIPE_RND_MODE_EN
      .rnd_mode  (rnd_mode),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .out_tag   (out_tag)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Driver: one operation with out_ready high, checking latency and outputs
   task automatic run_one(input string name, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] vr, input logic [4:0] vf, input logic [3:0] vt);
      int n;
      @(negedge clk);
      a        = va;
      b        = vb;
      in_tag   = vt;
      in_valid = 1'b1;
      #1;
      check({name, "_in_ready"}, in_ready, 1);
      n = 0;
      while (n < 12) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) break;
      end
      check({name, "_latency"}, n, 4);
      check({name, "_result"}, result, vr);
      check({name, "_flags"}, flags, vf);
      check({name, "_tag"}, out_tag, vt);
   endtask

   // Driver + scoreboard: 8 back-to-back tagged ops with a 3-cycle output stall
   task automatic run_stream();
      int sent;
      int got;
      int cyc;
      int k;
      logic [SB_W-1:0] e;
      logic [SB_W-1:0] hold;
      sent = 0;
      got  = 0;
      cyc  = 0;
      hold = '0;
      exp_q.delete();
      while ((got < 8) && (cyc < 100)) begin
         @(negedge clk);
         cyc++;
         out_ready = !((cyc >= 5) && (cyc <= 7));
         k = (sent * 2) % N_VEC;
         if (sent < 8) begin
            a        = VA[k];
            b        = VB[k];
            in_tag   = 4'(sent + 3);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!out_ready) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            if (cyc == 5) hold = {out_tag, flags, result};
            else check("stall_hold", {out_tag, flags, result}, hold);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({4'(sent + 3), VF[k], VR[k]});
            sent++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("stream_extra", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("stream_result", result, e[15:0]);
               check("stream_flags", flags, e[20:16]);
               check("stream_tag", out_tag, e[24:21]);
            end
            got++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_count", got, 8);
      check("stream_queue_empty", exp_q.size(), 0);
      k = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) k++;
      end
      check("stream_no_dup", k, 0);
   endtask

   // Reset with operations in flight
   task automatic run_reset();
      int k;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a        = VA[i];
         b        = VB[i];
         in_tag   = 4'(9 + i);
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("rst_pre_out_valid", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", flags, 0);
      check("rst_out_tag", out_tag, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_in_ready", in_ready, 1);
      @(negedge clk);
      check("rst_first_cycle_in_ready", in_ready, 1);
      k = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) k++;
      end
      check("rst_no_stale", k, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached checks=%0d", n_checks);
      $fatal(1, "tb_fp_mult_pipe timeout");
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_result", result, 0);
      check("reset_flags", flags, 0);
      check("reset_out_tag", out_tag, 0);
      rst = 1'b0;
      #1;
      check("reset_in_ready", in_ready, 1);

      for (int i = 0; i < N_VEC; i++) begin
         run_one($sformatf("vec%0d", i), VA[i], VB[i], VR[i], VF[i], 4'(i));
      end

`ifdef FP_MULT_PIPE_RND_MODE_EN
      rnd_mode = 2'd1;
      run_one("rtz_3c01", 16'h3C01, 16'h3C01, 16'h3C02, 5'h01, 4'd1);
      run_one("rtz_ovf", 16'h7BFF, 16'h4000, 16'h7BFF, 5'h05, 4'd2);
      rnd_mode = 2'd2;
      run_one("rup_3c01", 16'h3C01, 16'h3C01, 16'h3C03, 5'h01, 4'd3);
      run_one("rup_neg_ovf", 16'hFBFF, 16'h4000, 16'hFBFF, 5'h05, 4'd4);
      rnd_mode = 2'd3;
      run_one("rdn_neg_ovf", 16'hFBFF, 16'h4000, 16'hFC00, 5'h05, 4'd5);
      run_one("rdn_pos_ovf", 16'h7BFF, 16'h4000, 16'h7BFF, 5'h05, 4'd6);
      rnd_mode = 2'd0;
`endif

      run_stream();
      run_reset();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
